// File: rtl/sl_pkg.sv
// sl_pkg: shared SL register bit positions, config reset value and transmitter states
package sl_pkg;
   localparam int CFG_PCE  = 0;
   localparam int CFG_BQL  = 1;
   localparam int CFG_BQH  = 6;
   localparam int CFG_MODE = 7;
   localparam int CFG_IRQM = 8;
   localparam int CFG_EIN  = 9;
   localparam int ST_TXB = 0;
   localparam int ST_TXD = 1;
   localparam int ST_REJ = 2;
   localparam logic [15:0] CFG_RESET = 16'h0010;
   typedef enum logic [2:0] {RESET_GAP, IDLE, BIT_LOW, BIT_GAP, STOP_LOW, STOP_GAP} sl_tx_state_e;
   function automatic logic bq_legal(input logic [5:0] bq);
      return !bq[0] && bq >= 6'd8 && bq <= 6'd32;
   endfunction
endpackage

// File: rtl/sl_tx_symbol_timer.sv
// sl_tx_symbol_timer: loadable down-counter flagging the last cycle of a low or gap phase
module sl_tx_symbol_timer #(
   parameter int W = 4,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         phase_done
);
   logic [W-1:0] count;
   // load with length-1 so the phase lasts exactly load_value cycles, then hold at zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= INIT;
      else if (load) count <= load_value - W'(1);
      else if (count != '0) count <= count - W'(1);
   assign phase_done = count == '0;
endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: SL word serialiser (data LSB-first, odd parity, stop); SL_TX_ERR_INJECT_EN adds EIN parity inversion
module sl_transmitter import sl_pkg::*; #(
   parameter int STATUS_WIDTH   = 16,
   parameter int CONFIG_WIDTH   = 16,
   parameter int BIT_LOW_CYCLES = 8,
   parameter int BIT_GAP_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CONFIG_WIDTH-1:0] wr_config_w,
   input  logic                    wr_enable,
   input  logic [31:0]             data_in,
   input  logic                    data_wr,
   output logic                    serial_line_zeroes_o,
   output logic                    serial_line_ones_o,
   output logic [STATUS_WIDTH-1:0] status_w,
   output logic [CONFIG_WIDTH-1:0] r_config_w,
   output logic                    data_status_changed
);
   localparam int TW = $clog2((BIT_LOW_CYCLES > BIT_GAP_CYCLES ? BIT_LOW_CYCLES : BIT_GAP_CYCLES) + 1);
`ifdef SL_TX_ERR_INJECT_EN
   localparam logic [CONFIG_WIDTH-1:0] CFG_MASK = CONFIG_WIDTH'(16'h03FF);
`else
   localparam logic [CONFIG_WIDTH-1:0] CFG_MASK = CONFIG_WIDTH'(16'h01FF);
`endif
   sl_tx_state_e state, state_nx;
   logic [CONFIG_WIDTH-1:0] cfg;
   logic [5:0] bq, bq_l, idx;
   logic [31:0] data_l, mask;
   logic par, par_l, sym, done, load, txd, rej, dsc, zeroes, ones;
   logic [TW-1:0] load_value;
   assign bq = cfg[CFG_BQH:CFG_BQL];
   assign mask = (bq == 6'd32) ? '1 : (32'd1 << bq) - 32'd1;
`ifdef SL_TX_ERR_INJECT_EN
   assign par = ~^(data_in & mask) ^ cfg[CFG_EIN];
`else
   assign par = ~^(data_in & mask);
`endif
   assign sym = (idx == bq_l) ? par_l : data_l[idx[4:0]];
   sl_tx_symbol_timer #(.W(TW), .INIT(TW'(BIT_GAP_CYCLES - 1))) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_value (load_value),
      .phase_done (done)
   );
   // state register; reset lands in the startup gap
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= RESET_GAP;
      else state <= state_nx;
   // next state and timer reload on every phase change
   always_comb begin
      state_nx = state;
      load = 1'b0;
      load_value = TW'(BIT_GAP_CYCLES);
      case (state)
         RESET_GAP: if (done) state_nx = IDLE;
         IDLE: if (data_wr) begin
            state_nx = BIT_LOW;
            load = 1'b1;
            load_value = TW'(BIT_LOW_CYCLES);
         end
         BIT_LOW: if (done) begin
            state_nx = BIT_GAP;
            load = 1'b1;
         end
         BIT_GAP: if (done) begin
            state_nx = (idx == bq_l) ? STOP_LOW : BIT_LOW;
            load = 1'b1;
            load_value = TW'(BIT_LOW_CYCLES);
         end
         STOP_LOW: if (done) begin
            state_nx = STOP_GAP;
            load = 1'b1;
         end
         STOP_GAP: if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // config, word latch, symbol index, status flags and registered line drivers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cfg <= CONFIG_WIDTH'(CFG_RESET);
         bq_l <= '0;
         data_l <= '0;
         par_l <= 1'b0;
         idx <= '0;
         txd <= 1'b0;
         rej <= 1'b0;
         dsc <= 1'b0;
         zeroes <= 1'b1;
         ones <= 1'b1;
      end else begin
         dsc <= 1'b0;
         if (state == IDLE && wr_enable && bq_legal(wr_config_w[CFG_BQH:CFG_BQL])) cfg <= wr_config_w & CFG_MASK;
         if (state == IDLE && data_wr) begin
            data_l <= data_in & mask;
            bq_l <= bq;
            par_l <= par;
            idx <= '0;
            txd <= 1'b0;
            rej <= 1'b0;
         end else if (data_wr) begin
            rej <= 1'b1;
            dsc <= 1'b1;
         end
         if (state == BIT_GAP && done) idx <= idx + 6'd1;
         if (state == STOP_GAP && done) begin
            txd <= 1'b1;
            dsc <= 1'b1;
         end
         zeroes <= !((state == BIT_LOW && !sym) || state == STOP_LOW);
         ones <= !((state == BIT_LOW && sym) || state == STOP_LOW);
      end
   // status register image
   always_comb begin
      status_w = '0;
      status_w[ST_TXB] = state != IDLE;
      status_w[ST_TXD] = txd;
      status_w[ST_REJ] = rej;
   end
   assign r_config_w = cfg;
   assign data_status_changed = dsc;
   assign serial_line_zeroes_o = zeroes;
   assign serial_line_ones_o = ones;
endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: table, hand-written and random frames checked against a symbol-list line model
module tb_sl_transmitter;
   localparam int LOW = 8;
   localparam int GAP = 8;
   localparam int SYM = LOW + GAP;
`ifdef SL_TX_ERR_INJECT_EN
   localparam logic [15:0] CMASK = 16'h03FF;
`else
   localparam logic [15:0] CMASK = 16'h01FF;
`endif
   logic clk = 0, rst_n = 0, wr_enable = 0, data_wr = 0;
   logic [15:0] wr_config_w = '0;
   logic [31:0] data_in = '0;
   logic zl, ol, dsc;
   logic [15:0] status_w, r_config_w;
   int n_cmp = 0, n_fail = 0;
   logic [15:0] cfg_m = 16'h0010;
   typedef struct {logic [15:0] cfg; logic [15:0] exp_cfg; logic [31:0] word;} vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   sl_transmitter #(.STATUS_WIDTH(16), .CONFIG_WIDTH(16), .BIT_LOW_CYCLES(LOW), .BIT_GAP_CYCLES(GAP)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .wr_config_w          (wr_config_w),
      .wr_enable            (wr_enable),
      .data_in              (data_in),
      .data_wr              (data_wr),
      .serial_line_zeroes_o (zl),
      .serial_line_ones_o   (ol),
      .status_w             (status_w),
      .r_config_w           (r_config_w),
      .data_status_changed  (dsc)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic bit par_of(logic [31:0] w, int bq, bit inj);
      int c = 0;
      for (int i = 0; i < bq; i++) c += int'(w[i]);
      return ((c % 2) == 0) ^ inj;
   endfunction

   // expected {zeroes, ones} k cycles after the first line fall
   function automatic logic [1:0] exp_lines(logic [31:0] w, int bq, bit inj, int k);
      int s = k / SYM;
      bit b;
      if (k % SYM >= LOW) return 2'b11;
      if (s > bq) return 2'b00;
      b = (s == bq) ? par_of(w, bq, inj) : w[s];
      return b ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [15:0] cfg_model(logic [15:0] old, logic [15:0] v);
      int b = int'(v[6:1]);
      return (b % 2 == 0 && b >= 8 && b <= 32) ? (v & CMASK) : old;
   endfunction

   function automatic bit inj_now();
`ifdef SL_TX_ERR_INJECT_EN
      return cfg_m[9];
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic write_cfg(logic [15:0] v, logic [15:0] exp);
      @(negedge clk);
      wr_config_w = v;
      wr_enable = 1;
      @(negedge clk);
      wr_enable = 0;
      check("r_config_w", 32'(r_config_w), 32'(exp));
      cfg_m = exp;
   endtask

   task automatic start(logic [31:0] w);
      @(negedge clk);
      data_in = w;
      data_wr = 1;
      @(negedge clk);
      data_wr = 0;
   endtask

   task automatic wait_idle(string nm, int exp);
      int busy = 0;
      for (int i = 0; i < 100 && status_w[0]; i++) begin
         busy++;
         @(negedge clk);
      end
      check(nm, busy, exp);
   endtask

   // entered on the sample right after the accepting edge; optionally strobes a rejected word and a busy config write, or chains the next word
   task automatic watch(logic [31:0] w, int bq, bit inj, int rej_at, bit nxt, logic [31:0] nw);
      int frame = (bq + 2) * SYM;
      int busy, bad = 0, pulses = 0;
      logic [15:0] cfg0 = r_config_w;
      check("txb after strobe", 32'(status_w[0]), 1);
      busy = int'(status_w[0]);
      for (int k = 0; k < frame; k++) begin
         @(negedge clk);
         if ({zl, ol} !== exp_lines(w, bq, inj, k)) bad++;
         if (k < frame - 1) begin
            busy += int'(status_w[0]);
            pulses += int'(dsc);
         end
         if (k == rej_at) begin
            data_in = ~w;
            data_wr = 1;
            wr_config_w = 16'h0020;
            wr_enable = 1;
         end
         if (k == rej_at + 1) begin
            data_wr = 0;
            wr_enable = 0;
         end
      end
      check("frame line errors", bad, 0);
      check("busy cycles", busy, frame);
      check("reject pulses", pulses, (rej_at >= 0) ? 1 : 0);
      check("status at done", 32'(status_w), (rej_at >= 0) ? 6 : 2);
      check("done pulse", 32'(dsc), 1);
      check("config kept during frame", 32'(r_config_w), 32'(cfg0));
      if (nxt) begin
         data_in = nw;
         data_wr = 1;
      end
      @(negedge clk);
      data_wr = 0;
      check("pulse width", 32'(dsc), 0);
   endtask

   task automatic send(logic [31:0] w, int rej_at);
      start(w);
      watch(w, int'(cfg_m[6:1]), inj_now(), rej_at, 0, '0);
   endtask

   initial begin
      logic [15:0] v;
      logic [31:0] w1, w2;
      bit inj_old;
      vecs[0] = '{16'h0010, 16'h0010, 32'h0000_00A5};
      vecs[1] = '{16'h0040, 16'h0040, 32'hFFFF_FFFF};
      vecs[2] = '{16'h000E, 16'h0040, 32'h1234_5678};
      vecs[3] = '{16'h0044, 16'h0040, 32'h8000_0001};
      vecs[4] = '{16'h0199, 16'h0199, 32'h0000_0ABC};
`ifdef SL_TX_ERR_INJECT_EN
      vecs[5] = '{16'hFE14, 16'h0214, 32'h0000_03FF};
`else
      vecs[5] = '{16'hFE14, 16'h0014, 32'h0000_03FF};
`endif
      vecs[6] = '{16'h0030, 16'h0030, 32'h0080_0001};
      repeat (3) @(negedge clk);
      check("reset lines", 32'({zl, ol}), 3);
      check("reset status", 32'(status_w), 1);
      check("reset config", 32'(r_config_w), 32'h0010);
      check("reset pulse", 32'(dsc), 0);
      rst_n = 1;
      wait_idle("reset gap cycles", GAP);
      foreach (vecs[i]) begin
         write_cfg(vecs[i].cfg, vecs[i].exp_cfg);
         send(vecs[i].word, -1);
      end
      send(32'hC0FF_EE11, 30);
      w1 = 32'h00A5_5A3C;
      w2 = 32'h0000_0155;
      inj_old = inj_now();
      @(negedge clk);
      wr_config_w = 16'h0014;
      wr_enable = 1;
      data_in = w1;
      data_wr = 1;
      @(negedge clk);
      wr_enable = 0;
      data_wr = 0;
      check("config with simultaneous send", 32'(r_config_w), 32'h0014);
      watch(w1, 24, inj_old, -1, 1, w2);
      cfg_m = 16'h0014;
      watch(w2, 10, inj_now(), -1, 0, '0);
      for (int i = 0; i < 8; i++) begin
         v = (i % 3 == 2) ? 16'($urandom) : ((16'($urandom) & ~16'h007E) | 16'((8 + 2 * $urandom_range(0, 12)) << 1));
         write_cfg(v, cfg_model(cfg_m, v));
         send($urandom, -1);
      end
      start(32'hDEAD_BEEF);
      repeat (20) @(negedge clk);
      rst_n = 0;
      #1;
      check("mid-word reset lines", 32'({zl, ol}), 3);
      check("mid-word reset status", 32'(status_w), 1);
      check("mid-word reset config", 32'(r_config_w), 32'h0010);
      check("mid-word reset pulse", 32'(dsc), 0);
      @(negedge clk);
      rst_n = 1;
      cfg_m = 16'h0010;
      wait_idle("gap after mid-word reset", GAP);
      send(32'h0000_005A, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
